// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg: shared pipeline types for hazard control and forwarding.  Rev 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter: saturating up-counter with synchronous clear.  Rev 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear takes precedence over an increment in the same cycle.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl: RAW/memory-wait stall and branch flush control.  Rev 1.0
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fwd_en,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  clr_stats,
    output logic                  freeze,
    output logic                  hazard,
    output logic                  flush,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic w_hit_exe;
    logic w_hit_mem;
    logic w_raw;
    logic w_stall;
    logic w_err;

    assign w_hit_exe = (id_use_src1 && (id_src1 == exe_dest)) ||
                       (id_two_src  && (id_src2 == exe_dest));
    assign w_hit_mem = (id_use_src1 && (id_src1 == mem_dest)) ||
                       (id_two_src  && (id_src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_raw = fwd_en ? (w_hit_exe && exe_wb_en && exe_mem_r_en)
                          : ((w_hit_exe && exe_wb_en) || (w_hit_mem && mem_wb_en));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        w_stall = 1'b0;
        w_err   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    w_stall = 1'b1;
                    state_d = WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    w_stall = 1'b1;
                    if (timer_q == TMR_LAST) begin
                        state_d = ERR;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ERR: begin
                w_err   = 1'b1;
                state_d = RUN;
                timer_d = '0;
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Outputs are forced low while reset is held so they drop without a clock.
    always_comb begin
        mem_stall = w_stall && rst;
        mem_err   = w_err && rst;
        flush     = branch_taken && !mem_stall && rst;
        hazard    = w_raw && !flush && !mem_stall && rst;
        freeze    = mem_stall || hazard;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (freeze),
        .clr_i   (clr_stats),
        .count_o (stall_count)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush),
        .clr_i   (clr_stats),
        .count_o (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle model.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fwd_en, id_use_src1, id_two_src;
    logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
    logic             exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic             branch_taken, mem_req, mem_ready, clr_stats;
    logic             freeze, hazard, flush, mem_stall, mem_err;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .clr_stats    (clr_stats),
        .freeze       (freeze),
        .hazard       (hazard),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: length of the current stalled run, pending timeout pulse, counts.
    int m_stalled   = 0;
    bit m_err_next  = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    bit e_stall, e_err, e_flush, e_hazard, e_freeze;

    task automatic idle_inputs();
        fwd_en = 0; id_use_src1 = 0; id_two_src = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; clr_stats = 0;
    endtask

    task automatic model_reset();
        m_stalled = 0; m_err_next = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic model_eval();
        bit reads_exe, reads_mem, raw, busy;
        reads_exe = (id_use_src1 && id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest);
        reads_mem = (id_use_src1 && id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest);
        if (fwd_en) raw = reads_exe && exe_wb_en && exe_mem_r_en;
        else        raw = (reads_exe && exe_wb_en) || (reads_mem && mem_wb_en);
        busy     = (m_stalled > 0) || mem_req;
        e_err    = m_err_next;
        e_stall  = !m_err_next && busy && !mem_ready;
        e_flush  = branch_taken && !e_stall;
        e_hazard = raw && !e_flush && !e_stall;
        e_freeze = e_stall || e_hazard;
        if (!rst) begin
            e_err = 0; e_stall = 0; e_flush = 0; e_hazard = 0; e_freeze = 0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            if (clr_stats) begin
                m_stall_cnt = 0;
                m_flush_cnt = 0;
            end else begin
                if (e_freeze && m_stall_cnt < CNT_MAX) m_stall_cnt++;
                if (e_flush  && m_flush_cnt < CNT_MAX) m_flush_cnt++;
            end
            if (m_err_next) begin
                m_err_next = 0;
                m_stalled  = 0;
            end else if (e_stall) begin
                m_stalled++;
                if (m_stalled == MEM_TIMEOUT) begin
                    m_err_next = 1;
                    m_stalled  = 0;
                end
            end else begin
                m_stalled = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_req = 1; branch_taken = 1; id_use_src1 = 1; exe_wb_en = 1;
        rst = 0;
        #2;
        n_tests++; if ({freeze, hazard, flush, mem_stall, mem_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {freeze, hazard, flush, mem_stall, mem_err});
        end
        @(posedge clk); #1;
        n_tests++; if (stall_count !== 0 || flush_count !== 0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        idle_inputs();
        model_reset();
        rst = 1;
        #1;
    endtask

    task automatic test_raw_nofwd();
        idle_inputs();
        id_src1 = 3; id_use_src1 = 1; exe_dest = 3; exe_wb_en = 1;
        #1;
        n_tests++; if ({hazard, freeze, flush} !== 3'b110) begin
            n_fail++; $display("FAIL raw_exe_nofwd: got hfz=%b expected 110", {hazard, freeze, flush});
        end
        exe_wb_en = 0; mem_dest = 3; mem_wb_en = 1;
        #1;
        n_tests++; if (hazard !== 1'b1) begin
            n_fail++; $display("FAIL raw_mem_nofwd: got %b expected 1", hazard);
        end
        id_use_src1 = 0; id_two_src = 1; id_src2 = 4;
        #1;
        n_tests++; if (hazard !== 1'b0) begin
            n_fail++; $display("FAIL no_raw_src2: got %b expected 0", hazard);
        end
        tick();
    endtask

    task automatic test_raw_fwd();
        idle_inputs();
        fwd_en = 1; id_src1 = 3; id_use_src1 = 1; exe_dest = 3; exe_wb_en = 1;
        mem_dest = 3; mem_wb_en = 1;
        #1;
        n_tests++; if (hazard !== 1'b0) begin
            n_fail++; $display("FAIL fwd_no_load: got %b expected 0", hazard);
        end
        exe_mem_r_en = 1;
        #1;
        n_tests++; if ({hazard, freeze} !== 2'b11) begin
            n_fail++; $display("FAIL fwd_load_use: got hf=%b expected 11", {hazard, freeze});
        end
        tick();
    endtask

    task automatic test_mem_wait();
        idle_inputs();
        clr_stats = 1;
        tick();
        clr_stats = 0; mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if ({mem_stall, freeze} !== 2'b11) begin
                n_fail++; $display("FAIL wait_cycle%0d: got sf=%b expected 11", i, {mem_stall, freeze});
            end
            tick();
        end
        mem_ready = 1;
        #1;
        n_tests++; if (mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL ready_cycle: got %b expected 0", mem_stall);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++; if (stall_count !== 3) begin
            n_fail++; $display("FAIL wait_stall_count: got %0d expected 3", stall_count);
        end
        tick();
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        bit  seen   = 0;
        idle_inputs();
        mem_req = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_err) begin
                seen = 1;
                break;
            end
            if (mem_stall) stalls++;
            tick();
        end
        n_tests++; if (!seen || stalls != MEM_TIMEOUT) begin
            n_fail++; $display("FAIL timeout_len: got err=%0d stalls=%0d expected 1/%0d", seen, stalls, MEM_TIMEOUT);
        end
        n_tests++; if (mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL err_cycle_stall: got %b expected 0", mem_stall);
        end
        tick();
        #1;
        n_tests++; if ({mem_err, mem_stall} !== 2'b01) begin
            n_fail++; $display("FAIL after_err: got es=%b expected 01", {mem_err, mem_stall});
        end
        mem_ready = 1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_branch_in_wait();
        idle_inputs();
        id_src1 = 5; id_use_src1 = 1; exe_dest = 5; exe_wb_en = 1;
        branch_taken = 1; mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if ({flush, hazard, freeze} !== 3'b001) begin
                n_fail++; $display("FAIL branch_wait%0d: got fhz=%b expected 001", i, {flush, hazard, freeze});
            end
            tick();
        end
        mem_ready = 1;
        #1;
        n_tests++; if ({flush, hazard, mem_stall} !== 3'b100) begin
            n_fail++; $display("FAIL branch_release: got fhs=%b expected 100", {flush, hazard, mem_stall});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_saturate_and_async_reset();
        idle_inputs();
        clr_stats = 1;
        tick();
        clr_stats = 0;
        id_src2 = 7; id_two_src = 1; mem_dest = 7; mem_wb_en = 1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_tests++; if (stall_count !== 4'd15) begin
            n_fail++; $display("FAIL stall_saturate: got %0d expected 15", stall_count);
        end
        clr_stats = 1;
        tick();
        clr_stats = 0;
        #1;
        n_tests++; if (stall_count !== 0) begin
            n_fail++; $display("FAIL clr_wins: got %0d expected 0", stall_count);
        end
        idle_inputs();
        mem_req = 1; branch_taken = 1;
        tick();
        tick();
        #1;
        n_tests++; if (mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_wait: got %b expected 1", mem_stall);
        end
        rst = 0;
        #1;
        n_tests++; if ({freeze, hazard, flush, mem_stall, mem_err, stall_count, flush_count} !== '0) begin
            n_fail++; $display("FAIL reset_mid_wait: got %b expected all zero",
                {freeze, hazard, flush, mem_stall, mem_err, stall_count, flush_count});
        end
        idle_inputs();
        model_reset();
        rst = 1;
        tick();
    endtask

    task automatic test_random();
        logic [4+2*CNT_W:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            fwd_en       = 1'($urandom_range(0, 1));
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_use_src1  = 1'($urandom_range(0, 1));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_req      = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 3) == 0) || (i % 500 >= 450 ? 1'b0 : 1'b0);
            if (i % 500 >= 450) mem_ready = 1'b0;
            clr_stats    = ($urandom_range(0, 31) == 0);
            #1;
            model_eval();
            got = {freeze, hazard, flush, mem_stall, mem_err, stall_count, flush_count};
            exp = {e_freeze, e_hazard, e_flush, e_stall, e_err, CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt)};
            n_tests++; if (got !== exp) begin
                n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", i, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_raw_nofwd();
        test_raw_fwd();
        test_mem_wait();
        test_timeout();
        test_branch_in_wait();
        test_saturate_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
